// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, pad byte, padder state encoding and
// the initial hash value used by the block core.
package sha256_pkg;

    localparam int SHA256_WORD_W      = 32;
    localparam int SHA256_BLK_W       = 512;
    localparam int SHA256_BLK_WORDS   = SHA256_BLK_W / SHA256_WORD_W;
    localparam int SHA256_LEN_FIELD_W = 64;

    localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

    // Word carrying only the pad marker in message byte 0.
    localparam logic [SHA256_WORD_W-1:0] SHA256_PAD_WORD = {SHA256_PAD_BYTE, 24'h000000};

    typedef enum logic [1:0] {
        ACCUM     = 2'd0,
        EMIT      = 2'd1,
        PAD_EXTRA = 2'd2
    } pad_state_e;

    // H0..H7, H0 in the most significant word.
    localparam logic [255:0] SHA256_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Message word stream in, padded 512-bit block stream out.
// slave: the padder's view; master: the feeder/consumer view.
interface sha256_msg_padder_if;

    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_last;

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, blk_ready,
        output in_ready, blk_data, blk_valid, blk_last
    );

    modport master (
        output in_data, in_valid, in_last, in_bytes, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_last
    );

endinterface

// File: rtl/sha256_pad_word.sv
// Combinational word formatter: puts bytes in message order, zeroes the
// lanes past the valid count of a final word and drops the 0x80 marker
// into the first free lane. spill_o flags a full final word, whose marker
// has to go into the following word.
// With SHA256_PAD_BYTE_SWAP_EN defined the input is little-endian and is
// byte-reversed first; otherwise the MSB lane is the first byte.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  bytes_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        spill_o
);

    logic [31:0] ordered;
    logic [2:0]  n_eff;

`ifdef SHA256_PAD_BYTE_SWAP_EN
    assign ordered = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
`else
    assign ordered = data_i;
`endif

    // Non-final words are always full; counts above 4 saturate.
    assign n_eff   = (!last_i || bytes_i > 3'd4) ? 3'd4 : bytes_i;
    assign spill_o = last_i && (n_eff == 3'd4);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Lane gi is message byte gi of this word.
            assign word_o[31-8*gi -: 8] = (3'(gi) < n_eff)  ? ordered[31-8*gi -: 8] :
                                          (3'(gi) == n_eff) ? SHA256_PAD_BYTE :
                                                              8'h00;
        end
    endgenerate

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: collects a word stream into 16-word blocks,
// appends 0x80, zero fill and the 64-bit message bit length, and hands
// blocks out one at a time. A trailing extra block is generated when the
// marker or the length does not fit in the last data block.
// Optional: SHA256_PAD_BYTE_SWAP_EN selects little-endian input words.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    sha256_msg_padder_if.slave    bus
);

    pad_state_e  state_q, state_d;
    logic [3:0]  widx_q, widx_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [31:0] words_q [SHA256_BLK_WORDS];
    logic [31:0] words_d [SHA256_BLK_WORDS];
    logic        blk_last_q, blk_last_d;
    logic        pend_q, pend_d;      // an extra block follows the current one
    logic        xspill_q, xspill_d;  // extra block starts with the marker

    logic [31:0] fmt_word;
    logic        fmt_spill;
    logic        accept;
    logic [2:0]  n_eff;
    logic [LEN_W-1:0] len_next;
    logic [63:0] len_field_new;
    logic [63:0] len_field_cur;
    logic [4:0]  pad_pos;

    sha256_pad_word u_pad_word (
        .data_i  (bus.in_data),
        .bytes_i (bus.in_bytes),
        .last_i  (bus.in_last),
        .word_o  (fmt_word),
        .spill_o (fmt_spill)
    );

    assign accept        = bus.in_valid && bus.in_ready;
    assign n_eff         = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
    assign len_next      = count_q + LEN_W'({n_eff, 3'b000});
    assign len_field_new = 64'(len_next);
    assign len_field_cur = 64'(count_q);
    // Word index that receives the 0x80 marker (16 = next block).
    assign pad_pos       = {1'b0, widx_q} + {4'b0000, fmt_spill};

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            widx_q     <= '0;
            count_q    <= '0;
            blk_last_q <= 1'b0;
            pend_q     <= 1'b0;
            xspill_q   <= 1'b0;
            for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            count_q    <= count_d;
            blk_last_q <= blk_last_d;
            pend_q     <= pend_d;
            xspill_q   <= xspill_d;
            for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
                words_q[i] <= words_d[i];
            end
        end
    end

    // Next state: word storage, padding placement and block sequencing.
    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        count_d    = count_q;
        blk_last_d = blk_last_q;
        pend_d     = pend_q;
        xspill_d   = xspill_q;
        for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
            words_d[i] = words_q[i];
        end

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    words_d[widx_q] = fmt_word;
                    if (!bus.in_last) begin
                        count_d = count_q + LEN_W'(32);
                        widx_d  = widx_q + 4'd1;
                        if (widx_q == 4'd15) begin
                            state_d    = EMIT;
                            blk_last_d = 1'b0;
                            pend_d     = 1'b0;
                        end
                    end else begin
                        count_d = len_next;
                        state_d = EMIT;
                        if (fmt_spill && widx_q != 4'd15) begin
                            words_d[widx_q + 4'd1] = SHA256_PAD_WORD;
                        end
                        if (pad_pos <= 5'd13) begin
                            // Marker and length both fit in this block.
                            words_d[14] = len_field_new[63:32];
                            words_d[15] = len_field_new[31:0];
                            blk_last_d  = 1'b1;
                            pend_d      = 1'b0;
                        end else begin
                            blk_last_d = 1'b0;
                            pend_d     = 1'b1;
                            xspill_d   = (pad_pos == 5'd16);
                        end
                    end
                end
            end

            EMIT: begin
                if (bus.blk_ready) begin
                    // Clear the buffer so the next block starts zero-filled.
                    for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
                        words_d[i] = '0;
                    end
                    blk_last_d = 1'b0;
                    state_d    = pend_q ? PAD_EXTRA : ACCUM;
                    if (blk_last_q) begin
                        count_d = '0;
                        widx_d  = '0;
                    end
                end
            end

            PAD_EXTRA: begin
                for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
                    words_d[i] = '0;
                end
                words_d[0]  = xspill_q ? SHA256_PAD_WORD : 32'h0;
                words_d[14] = len_field_cur[63:32];
                words_d[15] = len_field_cur[31:0];
                blk_last_d  = 1'b1;
                pend_d      = 1'b0;
                xspill_d    = 1'b0;
                state_d     = EMIT;
            end

            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs decoded from registered state.
    always_comb begin
        bus.in_ready  = (state_q == ACCUM) && !rst;
        bus.blk_valid = (state_q == EMIT);
        bus.blk_last  = blk_last_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < SHA256_BLK_WORDS; gi++) begin : g_blk
            assign bus.blk_data[511-32*gi -: 32] = words_q[gi];
        end
    endgenerate

endmodule
